// File: rtl/reg_file_pkg.sv
// +----------------------------------------------------------------------+
// | reg_file_pkg : shared widths and counter type for reg_file_sb        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package reg_file_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int CNT_W      = 2;
  localparam int CNT_MAX    = 3;

  typedef logic [CNT_W-1:0] cnt_t;
endpackage

`default_nettype wire

// File: rtl/reg_file_sb_cnt.sv
// +----------------------------------------------------------------------+
// | reg_file_sb_cnt : saturating pending-write counter for one register  |
// | Options: REG_FILE_BYPASS_EN adds one_o.  Rev 1.0                     |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_file_sb_cnt
  import reg_file_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic zero_o,
`ifdef REG_FILE_BYPASS_EN
  output logic one_o,
`endif
  output logic underflow_o
);

  cnt_t cnt_q;
  cnt_t cnt_d;
  logic w_inc_ok;
  logic w_dec_ok;

  assign full_o      = (cnt_q == cnt_t'(CNT_MAX));
  assign zero_o      = (cnt_q == '0);
`ifdef REG_FILE_BYPASS_EN
  assign one_o       = (cnt_q == cnt_t'(1));
`endif
  assign underflow_o = dec_i && zero_o;
  assign w_inc_ok    = inc_i && !full_o;
  assign w_dec_ok    = dec_i && !zero_o;

  // An accepted reserve paired with a write cancels out, even at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (w_inc_ok && !dec_i) begin
      cnt_d = cnt_q + cnt_t'(1);
    end else if (w_dec_ok && !w_inc_ok) begin
      cnt_d = cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_file_sb.sv
// +----------------------------------------------------------------------+
// | reg_file_sb : 2R/1W register file with per-register write scoreboard |
// | Options: REG_FILE_BYPASS_EN forwards write data to reads. Rev 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic              RESERVE,
  input  logic [ADDR_W-1:0] RESADDRESS,
  output logic              RES_FULL,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              OUT1_VALID,
  output logic              OUT2_VALID,
  output logic              ERR
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              err_q;
  logic              err_d;

  logic [DEPTH-1:0]  w_full;
  logic [DEPTH-1:0]  w_zero;
  logic [DEPTH-1:0]  w_unf;
`ifdef REG_FILE_BYPASS_EN
  logic [DEPTH-1:0]  w_one;
`endif
  logic              w_in_is_r0;
  logic              w_res_is_r0;
  logic              w_wr_en;
  logic              w_res_en;

  // With ZERO_REG, address 0 is removed from every write and reserve path.
  assign w_in_is_r0  = (ZERO_REG != 0) && (INADDRESS == '0);
  assign w_res_is_r0 = (ZERO_REG != 0) && (RESADDRESS == '0);
  assign w_wr_en     = WRITE && !w_in_is_r0;
  assign RES_FULL    = w_full[RESADDRESS] && !w_res_is_r0;
  assign w_res_en    = RESERVE && !RES_FULL && !w_res_is_r0;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cnt
    reg_file_sb_cnt u_cnt (
      .CLK         (CLK),
      .RESET       (RESET),
      .inc_i       (w_res_en && (RESADDRESS == ADDR_W'(i))),
      .dec_i       (w_wr_en && (INADDRESS == ADDR_W'(i))),
      .full_o      (w_full[i]),
      .zero_o      (w_zero[i]),
`ifdef REG_FILE_BYPASS_EN
      .one_o       (w_one[i]),
`endif
      .underflow_o (w_unf[i])
    );
  end

  assign err_d = err_q || (|w_unf);
  assign ERR   = err_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (w_wr_en) begin
        regs_q[INADDRESS] <= IN;
      end
      err_q <= err_d;
    end
  end

  // Returns {valid, data} for one read port.
  function automatic logic [DATA_W:0] rd_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W:0] r;
    r = {w_zero[a], regs_q[a]};
`ifdef REG_FILE_BYPASS_EN
    if (w_wr_en && (INADDRESS == a)) begin
      r = {w_zero[a] | w_one[a], IN};
    end
`endif
    if ((ZERO_REG != 0) && (a == '0)) begin
      r = {1'b1, {DATA_W{1'b0}}};
    end
    return r;
  endfunction

  always_comb begin
    {OUT1_VALID, OUT1} = rd_port(OUT1ADDRESS);
    {OUT2_VALID, OUT2} = rd_port(OUT2ADDRESS);
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
// +----------------------------------------------------------------------+
// | tb_reg_file_sb : directed and randomized bench for reg_file_sb       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_reg_file_sb;
  localparam int N = 8;

  logic            CLK = 1'b0;
  logic            RESET, WRITE, RESERVE;
  logic [7:0]      IN;
  logic [2:0]      INADDRESS, RESADDRESS, A1, A2;
  logic [1:0][7:0] o1, o2;
  logic [1:0]      v1, v2, full, err;

  int checks = 0;
  int errors = 0;

  // Reference state, index 0 = ZERO_REG=0 instance, 1 = ZERO_REG=1 instance.
  logic [7:0] m_reg [2][N];
  int         m_cnt [2][N];
  bit         m_err [2];

  always #5 CLK = ~CLK;

  reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .RESERVE(RESERVE), .RESADDRESS(RESADDRESS), .RES_FULL(full[0]),
    .OUT1ADDRESS(A1), .OUT2ADDRESS(A2), .OUT1(o1[0]), .OUT2(o2[0]),
    .OUT1_VALID(v1[0]), .OUT2_VALID(v2[0]), .ERR(err[0]));

  reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut_z (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .RESERVE(RESERVE), .RESADDRESS(RESADDRESS), .RES_FULL(full[1]),
    .OUT1ADDRESS(A1), .OUT2ADDRESS(A2), .OUT1(o1[1]), .OUT2(o2[1]),
    .OUT1_VALID(v1[1]), .OUT2_VALID(v2[1]), .ERR(err[1]));

  function automatic void m_read(input int z, input int a, output logic [7:0] d, output logic v);
    if (z == 1 && a == 0) begin
      d = 8'h00; v = 1'b1;
    end else begin
      d = m_reg[z][a]; v = (m_cnt[z][a] == 0);
`ifdef REG_FILE_BYPASS_EN
      if (WRITE && int'(INADDRESS) == a) begin
        d = IN; v = (m_cnt[z][a] <= 1);
      end
`endif
    end
  endfunction

  task automatic m_step(input int z);
    int ia, ra, pre;
    bit wr, rs;
    ia = int'(INADDRESS);
    ra = int'(RESADDRESS);
    if (RESET) begin
      for (int i = 0; i < N; i++) begin m_reg[z][i] = 8'h00; m_cnt[z][i] = 0; end
      m_err[z] = 1'b0;
    end else begin
      wr  = WRITE && !(z == 1 && ia == 0);
      rs  = RESERVE && !(z == 1 && ra == 0) && (m_cnt[z][ra] < 3);
      pre = m_cnt[z][ia];
      if (wr) begin
        m_reg[z][ia] = IN;
        if (pre == 0) m_err[z] = 1'b1;
      end
      if (!(wr && rs && ia == ra)) begin
        if (rs) m_cnt[z][ra] = m_cnt[z][ra] + 1;
        if (wr && pre > 0) m_cnt[z][ia] = m_cnt[z][ia] - 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    m_step(0);
    m_step(1);
    @(negedge CLK);
  endtask

  task automatic set(input bit wr, input int ia, input logic [7:0] d, input bit rs, input int ra);
    WRITE = wr; INADDRESS = 3'(ia); IN = d; RESERVE = rs; RESADDRESS = 3'(ra);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; set(0, 0, 8'h00, 0, 0); tick(); RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; set(1, 3, 8'hEE, 1, 3); tick(); tick();
    RESET = 1'b0; A1 = 3'd3; A2 = 3'd7; set(0, 0, 8'h00, 0, 5);
    for (int z = 0; z < 2; z++) begin
      checks++; if (o1[z] !== 8'h00) begin errors++; $display("FAIL reset_out1[%0d] got %h exp 00", z, o1[z]); end
      checks++; if (o2[z] !== 8'h00) begin errors++; $display("FAIL reset_out2[%0d] got %h exp 00", z, o2[z]); end
      checks++; if (v1[z] !== 1'b1) begin errors++; $display("FAIL reset_valid1[%0d] got %b exp 1", z, v1[z]); end
      checks++; if (v2[z] !== 1'b1) begin errors++; $display("FAIL reset_valid2[%0d] got %b exp 1", z, v2[z]); end
      checks++; if (full[z] !== 1'b0) begin errors++; $display("FAIL reset_full[%0d] got %b exp 0", z, full[z]); end
      checks++; if (err[z] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d] got %b exp 0", z, err[z]); end
    end
  endtask

  task automatic test_write_read();
    do_reset();
    A1 = 3'd3; A2 = 3'd3;
    set(0, 0, 8'h00, 1, 3); tick();
    set(1, 3, 8'hA5, 0, 0); tick();
    set(0, 0, 8'h00, 0, 0);
    for (int z = 0; z < 2; z++) begin
      checks++; if (o1[z] !== 8'hA5) begin errors++; $display("FAIL wr_out1[%0d] got %h exp a5", z, o1[z]); end
      checks++; if (o2[z] !== 8'hA5) begin errors++; $display("FAIL wr_out2[%0d] got %h exp a5", z, o2[z]); end
      checks++; if ((v1[z] & v2[z]) !== 1'b1) begin errors++; $display("FAIL wr_valid[%0d] got %b%b exp 11", z, v1[z], v2[z]); end
      checks++; if (err[z] !== 1'b0) begin errors++; $display("FAIL wr_err[%0d] got %b exp 0", z, err[z]); end
    end
  endtask

  task automatic test_reserve_full();
    logic [7:0] dv [3];
    dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'h33;
    do_reset();
    A1 = 3'd5;
    for (int k = 0; k < 3; k++) begin
      set(0, 0, 8'h00, 1, 5);
      checks++; if (full[0] !== 1'b0) begin errors++; $display("FAIL full_early k=%0d got %b exp 0", k, full[0]); end
      tick();
    end
    set(0, 0, 8'h00, 0, 5);
    checks++; if (full[0] !== 1'b1) begin errors++; $display("FAIL full_at3 got %b exp 1", full[0]); end
    checks++; if (v1[0] !== 1'b0) begin errors++; $display("FAIL full_valid got %b exp 0", v1[0]); end
    set(0, 0, 8'h00, 1, 5);
    checks++; if (full[0] !== 1'b1) begin errors++; $display("FAIL full_4th got %b exp 1", full[0]); end
    tick();
    for (int k = 0; k < 3; k++) begin
      set(1, 5, dv[k], 0, 5); tick();
      set(0, 0, 8'h00, 0, 5);
      checks++; if (o1[0] !== dv[k]) begin errors++; $display("FAIL drain_data k=%0d got %h exp %h", k, o1[0], dv[k]); end
      checks++; if (v1[0] !== (k == 2)) begin errors++; $display("FAIL drain_valid k=%0d got %b exp %b", k, v1[0], k == 2); end
      checks++; if (full[0] !== 1'b0) begin errors++; $display("FAIL drain_full k=%0d got %b exp 0", k, full[0]); end
    end
    checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL drain_err got %b exp 0", err[0]); end
  endtask

  task automatic test_err_sticky();
    do_reset();
    A1 = 3'd2;
    set(1, 2, 8'h5A, 0, 0);
    checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL err_same_cycle got %b exp 0", err[0]); end
    tick();
    set(0, 0, 8'h00, 0, 0);
    checks++; if (o1[0] !== 8'h5A) begin errors++; $display("FAIL err_data got %h exp 5a", o1[0]); end
    checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL err_rise got %b exp 1", err[0]); end
    set(0, 0, 8'h00, 1, 1); tick();
    set(1, 1, 8'h01, 1, 4); tick();
    set(0, 0, 8'h00, 0, 0);
    checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err[0]); end
    do_reset();
    set(0, 0, 8'h00, 0, 0);
    checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err[0]); end
  endtask

  task automatic test_same_cycle();
    logic [7:0] e_d;
    logic       e_v;
    do_reset();
    A1 = 3'd4;
    set(0, 0, 8'h00, 1, 4); tick();
    set(1, 4, 8'h77, 1, 4);
`ifdef REG_FILE_BYPASS_EN
    e_d = 8'h77; e_v = 1'b1;
`else
    e_d = 8'h00; e_v = 1'b0;
`endif
    checks++; if (full[0] !== 1'b0) begin errors++; $display("FAIL pair1_full got %b exp 0", full[0]); end
    checks++; if (o1[0] !== e_d) begin errors++; $display("FAIL pair1_data got %h exp %h", o1[0], e_d); end
    checks++; if (v1[0] !== e_v) begin errors++; $display("FAIL pair1_valid got %b exp %b", v1[0], e_v); end
    tick();
    set(0, 0, 8'h00, 0, 4);
    checks++; if (o1[0] !== 8'h77) begin errors++; $display("FAIL pair1_after_data got %h exp 77", o1[0]); end
    checks++; if (v1[0] !== 1'b0) begin errors++; $display("FAIL pair1_after_valid got %b exp 0", v1[0]); end
    set(0, 0, 8'h00, 1, 4); tick();
    set(0, 0, 8'h00, 1, 4); tick();
    set(1, 4, 8'h88, 1, 4);
    checks++; if (full[0] !== 1'b1) begin errors++; $display("FAIL pair3_full got %b exp 1", full[0]); end
    tick();
    set(0, 0, 8'h00, 0, 4);
    checks++; if (full[0] !== 1'b0) begin errors++; $display("FAIL pair3_after_full got %b exp 0", full[0]); end
    checks++; if (o1[0] !== 8'h88) begin errors++; $display("FAIL pair3_data got %h exp 88", o1[0]); end
    set(1, 4, 8'h99, 0, 0); tick();
    set(0, 0, 8'h00, 0, 0);
    checks++; if (v1[0] !== 1'b0) begin errors++; $display("FAIL pair3_cnt1_valid got %b exp 0", v1[0]); end
    set(1, 4, 8'hAA, 0, 0); tick();
    set(0, 0, 8'h00, 0, 0);
    checks++; if (v1[0] !== 1'b1) begin errors++; $display("FAIL pair3_cnt0_valid got %b exp 1", v1[0]); end
    checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL pair3_err got %b exp 0", err[0]); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    A1 = 3'd0; A2 = 3'd0;
    set(0, 0, 8'h00, 1, 0);
    checks++; if (full[1] !== 1'b0) begin errors++; $display("FAIL zr_full got %b exp 0", full[1]); end
    tick();
    set(1, 0, 8'hFF, 0, 0);
    checks++; if ({o1[1], v1[1]} !== {8'h00, 1'b1}) begin errors++; $display("FAIL zr_during got %h/%b exp 00/1", o1[1], v1[1]); end
    tick();
    set(0, 0, 8'h00, 0, 0);
    checks++; if (o1[1] !== 8'h00) begin errors++; $display("FAIL zr_data got %h exp 00", o1[1]); end
    checks++; if (v1[1] !== 1'b1) begin errors++; $display("FAIL zr_valid got %b exp 1", v1[1]); end
    checks++; if (err[1] !== 1'b0) begin errors++; $display("FAIL zr_err got %b exp 0", err[1]); end
    checks++; if (o1[0] !== 8'hFF) begin errors++; $display("FAIL nz_r0_data got %h exp ff", o1[0]); end
    for (int k = 0; k < 3; k++) begin set(0, 0, 8'h00, 1, 0); tick(); end
    set(0, 0, 8'h00, 0, 0);
    checks++; if (full[1] !== 1'b0) begin errors++; $display("FAIL zr_full3 got %b exp 0", full[1]); end
    checks++; if (full[0] !== 1'b1) begin errors++; $display("FAIL nz_full3 got %b exp 1", full[0]); end
    checks++; if (v2[1] !== 1'b1) begin errors++; $display("FAIL zr_valid3 got %b exp 1", v2[1]); end
  endtask

  task automatic test_bypass();
    logic [7:0] e_d;
    logic       e_v;
    do_reset();
    A1 = 3'd6; A2 = 3'd2;
    set(0, 0, 8'h00, 1, 6); tick();
    set(1, 6, 8'h42, 0, 0); tick();
    set(0, 0, 8'h00, 1, 6); tick();
    set(1, 6, 8'h3C, 0, 0);
`ifdef REG_FILE_BYPASS_EN
    e_d = 8'h3C; e_v = 1'b1;
`else
    e_d = 8'h42; e_v = 1'b0;
`endif
    checks++; if (o1[0] !== e_d) begin errors++; $display("FAIL byp_data got %h exp %h", o1[0], e_d); end
    checks++; if (v1[0] !== e_v) begin errors++; $display("FAIL byp_valid got %b exp %b", v1[0], e_v); end
    checks++; if ({o2[0], v2[0]} !== {8'h00, 1'b1}) begin errors++; $display("FAIL byp_other got %h/%b exp 00/1", o2[0], v2[0]); end
    tick();
    set(0, 0, 8'h00, 0, 0);
    checks++; if ({o1[0], v1[0]} !== {8'h3C, 1'b1}) begin errors++; $display("FAIL byp_next got %h/%b exp 3c/1", o1[0], v1[0]); end
  endtask

  task automatic test_random();
    logic [7:0] ed;
    logic       ev;
    int         ia, st;
    do_reset();
    for (int it = 0; it < 500; it++) begin
      RESET = ($urandom_range(0, 39) == 0);
      ia = $urandom_range(0, N - 1);
      // Mostly retire writes against outstanding reserves so ERR is not stuck high.
      if ($urandom_range(0, 3) != 0) begin
        st = $urandom_range(0, N - 1);
        for (int j = 0; j < N; j++) begin
          if (m_cnt[0][(st + j) % N] > 0) begin ia = (st + j) % N; break; end
        end
      end
      A1 = 3'($urandom_range(0, N - 1));
      A2 = 3'($urandom_range(0, N - 1));
      set($urandom_range(0, 1) == 1, ia, 8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, N - 1));
      for (int z = 0; z < 2; z++) begin
        m_read(z, int'(A1), ed, ev);
        checks++; if ({o1[z], v1[z]} !== {ed, ev}) begin errors++; $display("FAIL rnd_port1[%0d] it=%0d got %h/%b exp %h/%b", z, it, o1[z], v1[z], ed, ev); end
        m_read(z, int'(A2), ed, ev);
        checks++; if ({o2[z], v2[z]} !== {ed, ev}) begin errors++; $display("FAIL rnd_port2[%0d] it=%0d got %h/%b exp %h/%b", z, it, o2[z], v2[z], ed, ev); end
        ev = !(z == 1 && RESADDRESS == 3'd0) && (m_cnt[z][int'(RESADDRESS)] == 3);
        checks++; if (full[z] !== ev) begin errors++; $display("FAIL rnd_full[%0d] it=%0d got %b exp %b", z, it, full[z], ev); end
        checks++; if (err[z] !== m_err[z]) begin errors++; $display("FAIL rnd_err[%0d] it=%0d got %b exp %b", z, it, err[z], m_err[z]); end
      end
      tick();
    end
    RESET = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b1; WRITE = 1'b0; RESERVE = 1'b0; IN = 8'h00;
    INADDRESS = 3'd0; RESADDRESS = 3'd0; A1 = 3'd0; A2 = 3'd0;
    @(negedge CLK);
    test_reset();
    test_write_read();
    test_reserve_full();
    test_err_sticky();
    test_same_cycle();
    test_zero_reg();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with a per-register outstanding-write scoreboard for the next processor datapath. It provides two asynchronous read ports and one synchronous write port, as the current 8×8 file does, generalised in width and depth. Each register has a saturating pending-write counter, so decode can tell whether a read operand is current. It sits between decode (reserve and read) and writeback (write).

## Interface
- DATA_W, 8: register width in bits.
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 0: when 1, register 0 always reads 0 and ignores writes and reserves.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- IN  in  DATA_W  writeback data.
- INADDRESS  in  ADDR_W  writeback address.
- WRITE  in  1  writeback strobe.
- RESERVE  in  1  decode announces a future write to RESADDRESS.
- RESADDRESS  in  ADDR_W  reserved destination.
- RES_FULL  out  1  combinational; the counter at RESADDRESS is at its maximum, so a reserve this cycle is rejected.
- OUT1ADDRESS, OUT2ADDRESS  in  ADDR_W  read addresses.
- OUT1, OUT2  out  DATA_W  combinational read data.
- OUT1_VALID, OUT2_VALID  out  1  combinational; no write is outstanding to that register.
- ERR  out  1  sticky; a write arrived at a register with a pending count of 0.

## Operation
- State:
  - registers[DEPTH], each DATA_W bits.
  - cnt[DEPTH], each 2 bits, saturating at CNT_MAX = 3.
  - err, 1 bit.
- Read:
  - OUTn = registers[OUTnADDRESS].
  - OUTn_VALID = (cnt[OUTnADDRESS] == 0).
  - Both are zero-delay, with no # delays anywhere in the RTL.
- Write: on the edge with WRITE=1, registers[INADDRESS] <= IN. If cnt[INADDRESS] > 0 it decrements; otherwise it stays 0 and err <= 1.
- Reserve: on the edge with RESERVE=1 and cnt[RESADDRESS] < 3, cnt increments. At 3, RES_FULL=1 and cnt is unchanged; decode must stall and retry.
- Simultaneous WRITE and RESERVE to the same address: the net counter change is 0. Registers are still written. RES_FULL is evaluated on the pre-edge count, so a reserve at count 3 is rejected even with a concurrent write.
- Simultaneous WRITE and RESERVE to different addresses: both take effect independently.
- ZERO_REG=1:
  - Address 0 reads 0 with VALID=1.
  - Writes and reserves to address 0 are ignored.
  - ERR is never set by address 0.
  - RES_FULL is 0 for address 0.
- Reset: on an edge with RESET=1, every register is cleared to 0, every cnt to 0 and err to 0. RESET overrides a concurrent WRITE or RESERVE.
- Outputs one cycle after reset: OUTn=0, OUTn_VALID=1, RES_FULL=0, ERR=0.

## Timing
- Write latency is 1 edge; without bypass, data is visible on OUTn from the cycle after WRITE.
- Reserve latency is 1 edge; OUTn_VALID drops in the cycle after RESERVE.
- No backpressure on WRITE; it is always accepted.
- RESERVE is accepted only when RES_FULL=0 in the same cycle.
- ERR rises in the cycle after the offending write and holds until RESET.

## Configuration
- Macro: REG_FILE_BYPASS_EN.
- Defined: when WRITE=1 and INADDRESS == OUTnADDRESS (address ≠ 0 if ZERO_REG=1):
  - OUTn = IN in the same cycle.
  - OUTn_VALID = (cnt ≤ 1), reflecting the post-write count. A concurrent same-address RESERVE does not clear it.
- Undefined: reads always return stored state, and VALID reflects the pre-edge cnt.

## Structure
- Package reg_file_pkg holds:
  - default DATA_W and ADDR_W;
  - CNT_W = 2 and CNT_MAX = 3;
  - typedef cnt_t.
- Sub-module reg_file_sb_cnt: one saturating up/down counter with inc, dec, full, zero and underflow outputs. It is instantiated DEPTH times under a generate loop.
- The top level holds the data array, the read muxes, the bypass logic and err.

## Test plan
- Reset, then write 8'hA5 to r3; next cycle read r3 on both ports → OUT1 = OUT2 = 8'hA5, both VALID=1, ERR=0.
- Reserve r5 three times → RES_FULL=1 at count 3; a fourth reserve is rejected. Three writes of 8'h11, 8'h22, 8'h33 → OUT1_VALID=1 only after the third, and OUT1 = 8'h33.
- Write r2 with no prior reserve → register updated, ERR=1 next cycle, ERR stays 1 through further writes and reserves, ERR=0 after RESET.
- Same-cycle WRITE and RESERVE on r4 at count 1 → count stays 1 and VALID stays 0. The same pair at count 3 → RES_FULL=1, reserve rejected, count goes to 2.
- ZERO_REG=1: write 8'hFF and reserve at r0 → OUT1=0, VALID=1, ERR=0, RES_FULL=0.
- With REG_FILE_BYPASS_EN: r6 at count 1, WRITE 8'h3C to r6 while reading r6 → OUT1=8'h3C and OUT1_VALID=1 in the same cycle. Without the macro: OUT1 is the old value and VALID=0 that cycle, then 8'h3C with VALID=1 the next cycle.
